axis_packet_fifo: RTL and testbench

Store-and-forward packet FIFO for AXI-Stream byte-multiple streams. It sits directly downstream of the width converter, on the narrow side, so the converter drains at full rate into buffering. A packet becomes visible at the output only after its tlast beat has been written. Downstream consumers, such as MAC/framers that must not underrun mid-packet, therefore see every packet contiguously.

---
 rtl/axis_pkg.sv | 20 ++
 rtl/axis_fifo_ram.sv | 27 ++
 rtl/axis_packet_fifo.sv | 115 +++++++++++
 tb/tb_axis_packet_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream packet FIFO: pointer/entry widths and
// the write-side state encoding used when packet dropping is built in.
package axis_pkg;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // One RAM entry is {tlast, tdata}.
  function automatic int unsigned beat_width(input int unsigned bytes);
    return bytes * 8 + 1;
  endfunction

  typedef enum logic {
    WR_NORMAL,
    WR_DROP
  } wr_state_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module axis_fifo_ram #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sresetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!sresetn)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Define AXIS_PACKET_FIFO_DROP_EN
// to discard packets that cannot fit instead of stalling the input forever.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int unsigned AXIS_BYTES = 1,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    drop_pulse
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef struct packed {
    logic                    tlast;
    logic [AXIS_BYTES*8-1:0] tdata;
  } axis_beat_t;

  logic [PTR_W-1:0] wr_ptr_tmp, wr_ptr_cmt, rd_ptr;
  logic             full, cmt_nonempty, in_hs, wr_en, rd_load;
  logic             drop_mode, drop_done;
  axis_beat_t       wr_beat, rd_beat;

  assign full         = (wr_ptr_tmp - rd_ptr) == DEPTH_P;
  assign cmt_nonempty = rd_ptr != wr_ptr_cmt;
  assign in_hs        = axis_i_tvalid && axis_i_tready;
  assign wr_en        = in_hs && !drop_mode;
  assign rd_load      = cmt_nonempty && (!axis_o_tvalid || axis_o_tready);

`ifdef AXIS_PACKET_FIFO_DROP_EN
  wr_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state      <= WR_NORMAL;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop_done;
    end
  end

  // Overflow is detected combinationally so the input never sees a stall
  // on the beat that would otherwise deadlock.
  always_comb begin
    state_nxt = state;
    drop_mode = (state == WR_DROP)
             || (full && (wr_ptr_cmt == rd_ptr))
             || ((wr_ptr_tmp - wr_ptr_cmt) == DEPTH_P);
    drop_done = in_hs && drop_mode && axis_i_tlast;
    if (in_hs && drop_mode) state_nxt = axis_i_tlast ? WR_NORMAL : WR_DROP;
  end

  assign axis_i_tready = sresetn && (!full || drop_mode);
`else
  assign drop_mode     = 1'b0;
  assign drop_done     = 1'b0;
  assign drop_pulse    = 1'b0;
  assign axis_i_tready = sresetn && !full;
`endif

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wr_ptr_tmp <= '0;
      wr_ptr_cmt <= '0;
      rd_ptr     <= '0;
    end else begin
      if (drop_done) begin
        wr_ptr_tmp <= wr_ptr_cmt;
      end else if (wr_en) begin
        wr_ptr_tmp <= wr_ptr_tmp + 1'b1;
        if (axis_i_tlast) wr_ptr_cmt <= wr_ptr_tmp + 1'b1;
      end
      if (rd_load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn)           axis_o_tvalid <= 1'b0;
    else if (rd_load)       axis_o_tvalid <= 1'b1;
    else if (axis_o_tready) axis_o_tvalid <= 1'b0;
  end

  assign wr_beat = '{tlast: axis_i_tlast, tdata: axis_i_tdata};

  axis_fifo_ram #(
    .WIDTH  (beat_width(AXIS_BYTES)),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .sresetn (sresetn),
    .we      (wr_en),
    .waddr   (wr_ptr_tmp[ADDR_W-1:0]),
    .wdata   (wr_beat),
    .re      (rd_load),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rdata   (rd_beat)
  );

  assign axis_o_tlast = rd_beat.tlast;
  assign axis_o_tdata = rd_beat.tdata;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo (DEPTH=8, AXIS_BYTES=1 and 4 in parallel).
module tb_axis_packet_fifo;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        i_tvalid, i_tlast, o_tready;
  logic [31:0] i_tdata;

  logic        tready1, ov1, ol1, dp1;
  logic [7:0]  od1;
  logic        tready4, ov4, ol4, dp4;
  logic [31:0] od4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_packet_fifo #(.AXIS_BYTES(1), .DEPTH(8)) u1 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(tready1), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
    .axis_i_tdata(i_tdata[7:0]),
    .axis_o_tready(o_tready), .axis_o_tvalid(ov1), .axis_o_tlast(ol1),
    .axis_o_tdata(od1), .drop_pulse(dp1)
  );

  axis_packet_fifo #(.AXIS_BYTES(4), .DEPTH(8)) u4 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(tready4), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
    .axis_i_tdata(i_tdata),
    .axis_o_tready(o_tready), .axis_o_tvalid(ov4), .axis_o_tlast(ol4),
    .axis_o_tdata(od4), .drop_pulse(dp4)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: collects delivered beats, counts drop pulses, checks AXIS hold rule.
  logic [8:0]  got1[$];
  logic [32:0] got4[$];
  int          dcnt1 = 0, dcnt4 = 0;
  bit          vseen = 0;
  logic        ps = 0, pr = 0, pv1 = 0, pl1 = 0, pv4 = 0, pl4 = 0;
  logic [7:0]  pd1 = '0;
  logic [31:0] pd4 = '0;

  always @(negedge clk) begin
    if (sresetn && ps && pv1 && !pr) chk("stable1", {ov1, ol1, od1}, {1'b1, pl1, pd1});
    if (sresetn && ps && pv4 && !pr) chk("stable4", {ov4, ol4, od4}, {1'b1, pl4, pd4});
    if (sresetn && ov1 && o_tready) got1.push_back({ol1, od1});
    if (sresetn && ov4 && o_tready) got4.push_back({ol4, od4});
    if (ov1 || ov4) vseen = 1;
    if (dp1) dcnt1++;
    if (dp4) dcnt4++;
    ps = sresetn; pr = o_tready;
    pv1 = ov1; pl1 = ol1; pd1 = od1;
    pv4 = ov4; pl4 = ol4; pd4 = od4;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got1.delete();
    got4.delete();
    dcnt1 = 0;
    dcnt4 = 0;
    vseen = 0;
  endtask

  task automatic do_reset();
    sresetn  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    o_tready = 1'b0;
    next_cycle();
    next_cycle();
    sresetn = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input string name);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    @(negedge clk);
    chk(name, {tready4, tready1}, 2'b11);
    next_cycle();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  typedef struct {
    logic        vld, last;
    logic [31:0] data;
    logic        ordy;
    logic        exp_irdy, exp_ov, exp_ol;
    logic [31:0] exp_od;
  } vec_t;

  vec_t tv[8];

  logic [32:0] expq[$];
  logic [32:0] pend[$];

  initial begin
    // Packet 11,22,33 accepted cycles 0-2; first output beat valid in cycle 4.
    tv[0] = '{1, 0, 32'h11, 1, 1, 0, 0, 32'h0};
    tv[1] = '{1, 0, 32'h22, 1, 1, 0, 0, 32'h0};
    tv[2] = '{1, 1, 32'h33, 1, 1, 0, 0, 32'h0};
    tv[3] = '{0, 0, 32'h0,  1, 1, 0, 0, 32'h0};
    tv[4] = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h11};
    tv[5] = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h22};
    tv[6] = '{0, 0, 32'h0,  1, 1, 1, 1, 32'h33};
    tv[7] = '{0, 0, 32'h0,  1, 1, 0, 0, 32'h0};

    sresetn  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    o_tready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_irdy",  {tready4, tready1}, 2'b00);
    chk("rst_ovalid", {ov4, ov1}, 2'b00);
    chk("rst_odata", {ol4, od4, ol1, od1}, '0);
    chk("rst_drop",  {dp4, dp1}, 2'b00);
    next_cycle();
    sresetn = 1'b1;

    // Test 1: latency and ordering table
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      i_tvalid = tv[i].vld;
      i_tlast  = tv[i].last;
      i_tdata  = tv[i].data;
      o_tready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("t1_irdy[%0d]", i), {tready4, tready1}, {tv[i].exp_irdy, tv[i].exp_irdy});
      chk($sformatf("t1_ov[%0d]", i), {ov4, ov1}, {tv[i].exp_ov, tv[i].exp_ov});
      if (tv[i].exp_ov) begin
        chk($sformatf("t1_od1[%0d]", i), {ol1, od1}, {tv[i].exp_ol, tv[i].exp_od[7:0]});
        chk($sformatf("t1_od4[%0d]", i), {ol4, od4}, {tv[i].exp_ol, tv[i].exp_od});
      end
      next_cycle();
    end
    i_tvalid = 1'b0;

    // Test 2: fill with output stalled; the output register holds one beat beyond the RAM
    do_reset();
    clear_mon();
    o_tready = 1'b0;
    for (int i = 1; i <= 9; i++) send(i, (i == 4 || i == 8 || i == 9), "t2_irdy_fill");
    @(negedge clk);
    chk("t2_full", {tready4, tready1}, 2'b00);
    chk("t2_hold", {ov1, od1}, {1'b1, 8'h01});
    next_cycle();
    o_tready = 1'b1;
    @(negedge clk);
    chk("t2_full_same_cycle", {tready4, tready1}, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("t2_freed", {tready4, tready1}, 2'b11);
    repeat (12) next_cycle();
    chk("t2_count1", got1.size(), 9);
    chk("t2_count4", got4.size(), 9);
    for (int i = 0; i < 9 && i < got1.size() && i < got4.size(); i++) begin
      chk("t2_beat1", got1[i], {(i == 3 || i == 7 || i == 8), 8'(i + 1)});
      chk("t2_beat4", got4[i], {(i == 3 || i == 7 || i == 8), 32'(i + 1)});
    end

    // Test 3: reset in the middle of a packet discards it
    do_reset();
    clear_mon();
    o_tready = 1'b1;
    send(32'h01, 1'b0, "t3_irdy");
    send(32'h02, 1'b0, "t3_irdy");
    sresetn = 1'b0;
    @(negedge clk);
    chk("t3_irdy_in_reset", {tready4, tready1}, 2'b00);
    next_cycle();
    sresetn = 1'b1;
    send(32'hAA, 1'b1, "t3_irdy_after");
    repeat (6) next_cycle();
    chk("t3_count", got1.size(), 1);
    if (got1.size() > 0) chk("t3_beat", got1[0], {1'b1, 8'hAA});

`ifdef AXIS_PACKET_FIFO_DROP_EN
    // Test 4: oversize packet dropped, following packet intact
    do_reset();
    clear_mon();
    o_tready = 1'b1;
    for (int i = 0; i < 10; i++) send(32'hC0 + i, (i == 9), "t4_irdy_long");
    send(32'h55, 1'b0, "t4_irdy_short");
    send(32'h66, 1'b1, "t4_irdy_short");
    repeat (8) next_cycle();
    chk("t4_drop1", dcnt1, 1);
    chk("t4_drop4", dcnt4, 1);
    chk("t4_count", got1.size(), 2);
    if (got1.size() == 2) begin
      chk("t4_beat0", got1[0], {1'b0, 8'h55});
      chk("t4_beat1", got1[1], {1'b1, 8'h66});
    end
`else
    // Test 5: oversize packet stalls permanently
    do_reset();
    clear_mon();
    o_tready = 1'b1;
    begin
      int sent = 0;
      for (int c = 0; c < 16; c++) begin
        i_tvalid = (sent < 10);
        i_tdata  = 32'hC0 + sent;
        i_tlast  = (sent == 9);
        @(negedge clk);
        if (i_tvalid && tready1) sent++;
        next_cycle();
      end
      i_tvalid = 1'b0;
      chk("t5_accepted", sent, 8);
    end
    @(negedge clk);
    chk("t5_irdy", {tready4, tready1}, 2'b00);
    chk("t5_never_valid", vseen, 0);
    chk("t5_no_drop", dcnt1 + dcnt4, 0);
    next_cycle();
`endif

    // Test 6: random throttling against a packet-level queue model
    do_reset();
    clear_mon();
    expq.delete();
    pend.delete();
    begin
      int pk = 0, idx = 0, cyc = 0;
      int len = $urandom_range(1, 8);
      bit hs;
      while (pk < 1000 && cyc < 60000) begin
        if (!i_tvalid && $urandom_range(0, 3) != 0) begin
          i_tvalid = 1'b1;
          i_tdata  = $urandom;
          i_tlast  = (idx == len - 1);
        end
        o_tready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        hs = i_tvalid && tready1;
        if (hs) begin
          pend.push_back({i_tlast, i_tdata});
          if (i_tlast) begin
            foreach (pend[k]) expq.push_back(pend[k]);
            pend.delete();
            pk++;
            idx = 0;
            len = $urandom_range(1, 8);
          end else begin
            idx++;
          end
        end
        next_cycle();
        if (hs) i_tvalid = 1'b0;
        cyc++;
      end
      i_tvalid = 1'b0;
      chk("rnd_budget", pk, 1000);
    end
    o_tready = 1'b1;
    for (int c = 0; c < 300 && (got1.size() < expq.size() || got4.size() < expq.size()); c++)
      next_cycle();
    next_cycle();
    chk("rnd_count1", got1.size(), expq.size());
    chk("rnd_count4", got4.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got1.size() && i < got4.size(); i++) begin
      logic [32:0] e;
      e = expq[i];
      chk("rnd_beat1", got1[i], {e[32], e[7:0]});
      chk("rnd_beat4", got4[i], e);
    end
    chk("rnd_no_drop", dcnt1 + dcnt4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
